// File: rtl/phase_rotator_param_if.sv
// Request/tap bundle between the CDR loop filter and the phase rotator.
// Latency and backpressure are set by the rotator; this file carries signals only.
interface phase_rotator_param_if #(
  parameter int NPH = 8,
  parameter int PW  = 3,
  parameter int SW  = 8
) ();
  logic                 inc;
  logic                 dec;
  logic                 load;
  logic [PW-1:0]        load_val;
  logic [NPH-1:0]       phase;
  logic                 clk_early;
  logic                 clk_edge;
  logic                 clk_late;
  logic [PW-1:0]        ptr;
  logic                 busy;
  logic                 drop;
  logic                 wrap_p;
  logic                 wrap_n;
  logic signed [SW-1:0] slip_cnt;

  modport master (
    output inc, dec, load, load_val, phase,
    input  clk_early, clk_edge, clk_late, ptr, busy, drop, wrap_p, wrap_n, slip_cnt
  );

  modport slave (
    input  inc, dec, load, load_val, phase,
    output clk_early, clk_edge, clk_late, ptr, busy, drop, wrap_p, wrap_n, slip_cnt
  );
endinterface

// File: rtl/phase_rotator_param.sv
// CDR phase rotator: registered pointer picks early/edge/late taps; ptr and taps move 1 clk after a request.
// No backpressure: requests arriving during hold-off, conflicting or at a saturated end are dropped and flagged.
module phase_rotator_param #(
  parameter int NPH       = 8,
  parameter int PW        = 3,
  parameter int EDGE_OFF  = 2,
  parameter int LATE_OFF  = 4,
  parameter int HOLDOFF   = 2,
  parameter int WRAP_MODE = 1,
  parameter int SW        = 8
) (
  input logic                  clk,
  input logic                  rst,
  phase_rotator_param_if.slave rot
);

  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLDOFF);
  localparam logic [PW-1:0] PTR_MAX = PW'(NPH - 1);
  localparam logic [PW-1:0] EDGE_STEP = PW'(EDGE_OFF % NPH);
  localparam logic [PW-1:0] LATE_STEP = PW'(LATE_OFF % NPH);
  localparam logic signed [SW-1:0] SLIP_MAX = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] SLIP_MIN = {1'b1, {(SW-1){1'b0}}};
  localparam bit WRAP = (WRAP_MODE != 0);

  logic [PW-1:0]        ptr_q, ptr_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 drop_q, drop_d;
  logic                 wrap_p_q, wrap_p_d;
  logic                 wrap_n_q, wrap_n_d;
  logic signed [SW-1:0] slip_q, slip_d;

  logic                 busy;
  logic [PW-1:0]        edge_idx;
  logic [PW-1:0]        late_idx;

  assign busy = (hold_q != '0);

  // Taps are plain muxes off the registered pointer; the clocks themselves never see a flop.
  assign edge_idx = ptr_q + EDGE_STEP;
  assign late_idx = ptr_q + LATE_STEP;

  assign rot.clk_early = rot.phase[ptr_q];
  assign rot.clk_edge  = rot.phase[edge_idx];
  assign rot.clk_late  = rot.phase[late_idx];

  assign rot.ptr      = ptr_q;
  assign rot.busy     = busy;
  assign rot.drop     = drop_q;
  assign rot.wrap_p   = wrap_p_q;
  assign rot.wrap_n   = wrap_n_q;
  assign rot.slip_cnt = slip_q;

  always_comb begin
    ptr_d    = ptr_q;
    hold_d   = busy ? hold_q - HW'(1) : hold_q;
    drop_d   = 1'b0;
    wrap_p_d = 1'b0;
    wrap_n_d = 1'b0;
    slip_d   = slip_q;

    if (rot.load) begin
      ptr_d  = rot.load_val;
      hold_d = HOLD_LD;
    end else if (rot.inc && rot.dec) begin
      drop_d = 1'b1;
    end else if ((rot.inc || rot.dec) && busy) begin
      drop_d = 1'b1;
    end else if (rot.inc && (ptr_q == PTR_MAX)) begin
      if (WRAP) begin
        ptr_d    = '0;
        hold_d   = HOLD_LD;
        wrap_p_d = 1'b1;
        if (slip_q != SLIP_MAX) slip_d = slip_q + SW'(1);
      end else begin
        drop_d = 1'b1;
      end
    end else if (rot.dec && (ptr_q == '0)) begin
      if (WRAP) begin
        ptr_d    = PTR_MAX;
        hold_d   = HOLD_LD;
        wrap_n_d = 1'b1;
        if (slip_q != SLIP_MIN) slip_d = slip_q - SW'(1);
      end else begin
        drop_d = 1'b1;
      end
    end else if (rot.inc) begin
      ptr_d  = ptr_q + PW'(1);
      hold_d = HOLD_LD;
    end else if (rot.dec) begin
      ptr_d  = ptr_q - PW'(1);
      hold_d = HOLD_LD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= '0;
      hold_q   <= '0;
      drop_q   <= 1'b0;
      wrap_p_q <= 1'b0;
      wrap_n_q <= 1'b0;
      slip_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      drop_q   <= drop_d;
      wrap_p_q <= wrap_p_d;
      wrap_n_q <= wrap_n_d;
      slip_q   <= slip_d;
    end
  end

endmodule

// File: tb/tb_phase_rotator_param.sv
// Directed bench for phase_rotator_param: three instances cover no-hold-off wrap, hold-off wrap and saturate modes.
module tb_phase_rotator_param;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  phase_rotator_param_if #(.NPH(8), .PW(3), .SW(4)) ia ();
  phase_rotator_param_if #(.NPH(8), .PW(3), .SW(8)) ib ();
  phase_rotator_param_if #(.NPH(8), .PW(3), .SW(8)) ic ();

  phase_rotator_param #(.NPH(8), .PW(3), .EDGE_OFF(2), .LATE_OFF(4), .HOLDOFF(0), .WRAP_MODE(1), .SW(4))
    u_a (.clk(clk), .rst(rst), .rot(ia.slave));
  phase_rotator_param #(.NPH(8), .PW(3), .EDGE_OFF(2), .LATE_OFF(4), .HOLDOFF(2), .WRAP_MODE(1), .SW(8))
    u_b (.clk(clk), .rst(rst), .rot(ib.slave));
  phase_rotator_param #(.NPH(8), .PW(3), .EDGE_OFF(2), .LATE_OFF(4), .HOLDOFF(2), .WRAP_MODE(0), .SW(8))
    u_c (.clk(clk), .rst(rst), .rot(ic.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pat;
  int ep;
  int es;
  logic exp_wrap;

  initial begin
    rst = 1'b0;
    ia.inc = 0; ia.dec = 0; ia.load = 0; ia.load_val = '0;
    ib.inc = 0; ib.dec = 0; ib.load = 0; ib.load_val = '0;
    ic.inc = 0; ic.dec = 0; ic.load = 0; ic.load_val = '0;
    pat = 8'b1011_0010;
    ia.phase = pat; ib.phase = 8'h0F; ic.phase = 8'h0F;
    #3;
    chk("rst_ptr_a", 32'(ia.ptr), 0);
    chk("rst_slip_a", 32'(ia.slip_cnt), 0);
    chk("rst_busy_b", 32'(ib.busy), 0);
    chk("rst_drop_b", 32'(ib.drop), 0);
    chk("rst_wrap_b", 32'({ib.wrap_p, ib.wrap_n}), 0);
    chk("rst_ptr_c", 32'(ic.ptr), 0);
    @(negedge clk);
    rst = 1'b1;

    // inc held for 9 cycles, no hold-off, wrapping
    ep = 0;
    ia.inc = 1;
    for (int i = 0; i < 9; i++) begin
      pat = 8'(8'hA5 ^ (i * 59));
      ia.phase = pat;
      tick();
      ep = (ep + 1) % 8;
      chk("a_ptr", 32'(ia.ptr), ep);
      chk("a_wrap_p", 32'(ia.wrap_p), (i == 7) ? 1 : 0);
      chk("a_early", 32'(ia.clk_early), 32'(pat[ep]));
      chk("a_edge", 32'(ia.clk_edge), 32'(pat[(ep + 2) % 8]));
      chk("a_late", 32'(ia.clk_late), 32'(pat[(ep + 4) % 8]));
    end
    ia.inc = 0;
    tick();
    chk("a_slip", 32'(ia.slip_cnt), 1);
    chk("a_wrap_clr", 32'(ia.wrap_p), 0);
    chk("a_busy", 32'(ia.busy), 0);

    // hold-off = 2: inc on 4 consecutive cycles
    ib.inc = 1;
    tick(); chk("b_ptr0", 32'(ib.ptr), 1); chk("b_drop0", 32'(ib.drop), 0); chk("b_busy0", 32'(ib.busy), 1);
    tick(); chk("b_ptr1", 32'(ib.ptr), 1); chk("b_drop1", 32'(ib.drop), 1); chk("b_busy1", 32'(ib.busy), 1);
    tick(); chk("b_ptr2", 32'(ib.ptr), 1); chk("b_drop2", 32'(ib.drop), 1); chk("b_busy2", 32'(ib.busy), 0);
    tick(); chk("b_ptr3", 32'(ib.ptr), 2); chk("b_drop3", 32'(ib.drop), 0); chk("b_busy3", 32'(ib.busy), 1);
    ib.inc = 0;
    tick(); chk("b_busy4", 32'(ib.busy), 1); chk("b_drop4", 32'(ib.drop), 0);
    tick(); chk("b_busy5", 32'(ib.busy), 0);

    // inc+dec conflict at ptr 3, then load while busy
    ib.load = 1; ib.load_val = 3'd3;
    tick(); chk("b_ld3", 32'(ib.ptr), 3);
    ib.load = 0;
    tick(); tick(); chk("b_ld3_idle", 32'(ib.busy), 0);
    ib.inc = 1; ib.dec = 1;
    tick(); chk("b_both_ptr", 32'(ib.ptr), 3); chk("b_both_drop", 32'(ib.drop), 1);
    ib.dec = 0;
    tick(); chk("b_inc_ptr", 32'(ib.ptr), 4); chk("b_inc_busy", 32'(ib.busy), 1);
    ib.load = 1; ib.load_val = 3'd6;
    tick(); chk("b_ld6_ptr", 32'(ib.ptr), 6); chk("b_ld6_drop", 32'(ib.drop), 0);
    chk("b_ld6_busy", 32'(ib.busy), 1);
    ib.load = 0; ib.inc = 0;
    tick(); chk("b_ld6_busy1", 32'(ib.busy), 1);
    tick(); chk("b_ld6_busy2", 32'(ib.busy), 0);

    // saturate mode at both ends
    ic.load = 1; ic.load_val = 3'd7;
    tick(); ic.load = 0;
    tick(); tick();
    ic.inc = 1;
    tick();
    chk("c_ptr7", 32'(ic.ptr), 7); chk("c_drop7", 32'(ic.drop), 1);
    chk("c_busy7", 32'(ic.busy), 0); chk("c_wrap_p", 32'(ic.wrap_p), 0);
    ic.inc = 0;
    tick(); chk("c_drop_clr", 32'(ic.drop), 0);
    ic.load = 1; ic.load_val = 3'd0;
    tick(); ic.load = 0;
    tick(); tick();
    ic.dec = 1;
    tick();
    chk("c_ptr0", 32'(ic.ptr), 0); chk("c_drop0", 32'(ic.drop), 1);
    chk("c_wrap_n", 32'(ic.wrap_n), 0); chk("c_slip", 32'(ic.slip_cnt), 0);
    ic.dec = 0;

    // repeated dec wraps with SW=4: slip saturates at -8
    ia.load = 1; ia.load_val = 3'd0;
    tick();
    ia.load = 0;
    chk("d_ld_ptr", 32'(ia.ptr), 0);
    chk("d_ld_slip", 32'(ia.slip_cnt), 1);
    chk("d_ld_wrap", 32'({ia.wrap_p, ia.wrap_n}), 0);
    ep = 0; es = 1;
    ia.dec = 1;
    for (int i = 0; i < 73; i++) begin
      if (i == 72) ib.inc = 1;
      tick();
      exp_wrap = (ep == 0);
      ep = (ep + 7) % 8;
      if (exp_wrap && es > -8) es--;
      chk("d_ptr", 32'(ia.ptr), ep);
      chk("d_wrap_n", 32'(ia.wrap_n), 32'(exp_wrap));
      chk("d_slip", 32'(ia.slip_cnt), es);
    end
    ia.dec = 0; ib.inc = 0;
    chk("d_slip_sat", 32'(ia.slip_cnt), -8);
    chk("d_b_busy", 32'(ib.busy), 1);

    // asynchronous reset mid-hold-off and mid-pulse
    #2 rst = 1'b0;
    #1;
    chk("r_ptr_a", 32'(ia.ptr), 0);
    chk("r_slip_a", 32'(ia.slip_cnt), 0);
    chk("r_wrap_a", 32'({ia.wrap_p, ia.wrap_n}), 0);
    chk("r_ptr_b", 32'(ib.ptr), 0);
    chk("r_busy_b", 32'(ib.busy), 0);
    chk("r_drop_b", 32'(ib.drop), 0);
    @(negedge clk);
    rst = 1'b1;
    ib.inc = 1;
    tick();
    chk("r_first_ptr", 32'(ib.ptr), 1);
    chk("r_first_drop", 32'(ib.drop), 0);
    ib.inc = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/phase_rotator_param.md
Name: phase_rotator_param

Overview:
Parametrised phase rotator for the CDR loop. It selects early, edge and late sampling clocks from an NPH-phase multiphase clock bus, driven by a registered pointer. The pointer is stepped by inc/dec pulses from the digital loop filter, or loaded directly. Over the previous generation it adds:
- configurable phase count and tap offsets
- a minimum spacing between steps (hold-off)
- wrap or saturate modes
- explicit rejection reporting
- a signed cycle-slip counter for lock and frequency-offset monitoring

Parameters:
NPH, 8, number of input phases; power of 2, at least 4
PW, 3, pointer width, equal to log2(NPH)
EDGE_OFF, 2, phase offset of the edge tap relative to the early tap, mod NPH
LATE_OFF, 4, phase offset of the late tap relative to the early tap, mod NPH
HOLDOFF, 2, number of cycles after any pointer change during which inc/dec are rejected; 0 disables hold-off
WRAP_MODE, 1, 1 = pointer wraps modulo NPH; 0 = pointer saturates at 0 and NPH-1
SW, 8, width of the signed slip counter

Ports:
clk  in  1  loop-filter clock
rst  in  1  reset; asynchronous, active-low
inc  in  1  step request: advance the pointer by 1
dec  in  1  step request: retard the pointer by 1
load  in  1  synchronous pointer load
load_val  in  PW  value loaded into the pointer
phase  in  NPH  multiphase clock bus; phase[i] lags phase[i-1]
clk_early  out  1  phase[ptr]
clk_edge  out  1  phase[(ptr+EDGE_OFF) mod NPH]
clk_late  out  1  phase[(ptr+LATE_OFF) mod NPH]
ptr  out  PW  current pointer (registered)
busy  out  1  high while the hold-off counter is non-zero
drop  out  1  one-cycle pulse: a request was rejected
wrap_p  out  1  one-cycle pulse: pointer wrapped from NPH-1 to 0
wrap_n  out  1  one-cycle pulse: pointer wrapped from 0 to NPH-1
slip_cnt  out  SW  signed net wrap count

Behaviour:
- Reset (rst=0, asynchronous): ptr=0, hold_cnt=0, busy=0, drop=0, wrap_p=0, wrap_n=0, slip_cnt=0.
- Tap selection:
  - The three clock outputs are purely combinational muxes driven from the registered ptr.
  - No clock path passes through flops.
  - Tap indices are computed modulo NPH by PW-bit addition truncation.
- Request priority is evaluated at each rising clk edge, in this order:
  1. load=1: ptr<=load_val; hold_cnt<=HOLDOFF. This applies even when busy=1 or inc/dec are also high. No drop and no wrap pulse is generated.
  2. inc=1 and dec=1: ptr is unchanged; drop=1.
  3. inc or dec while busy=1: ptr is unchanged; drop=1; hold_cnt keeps decrementing.
  4. inc=1 and ptr=NPH-1:
     - WRAP_MODE=1: ptr<=0, wrap_p=1, hold_cnt<=HOLDOFF.
     - WRAP_MODE=0: ptr is unchanged, drop=1, hold-off is not started.
  5. dec=1 and ptr=0:
     - WRAP_MODE=1: ptr<=NPH-1, wrap_n=1, hold_cnt<=HOLDOFF.
     - WRAP_MODE=0: ptr is unchanged, drop=1, hold-off is not started.
  6. inc: ptr<=ptr+1; dec: ptr<=ptr-1. Either case sets hold_cnt<=HOLDOFF.
  7. Otherwise, if hold_cnt is non-zero, it decrements.
- Hold-off timing: a step accepted at edge k causes requests at edges k+1 to k+HOLDOFF to be rejected. The next request is accepted at edge k+HOLDOFF+1. busy = (hold_cnt != 0).
- Pulse outputs: drop, wrap_p and wrap_n are registered and last exactly one cycle per event. They are 0 in every cycle with no event.
- slip_cnt:
  - Increments by 1 on each wrap_p event and decrements by 1 on each wrap_n event, updating in the same cycle the pulse is registered.
  - Saturates at +2^(SW-1)-1 and at -2^(SW-1); it does not wrap.
  - It is never changed by load.
  - It is constant at 0 when WRAP_MODE=0.
- Latency: ptr and the selected taps change one clk edge after the request is sampled.
- A reset asserted mid-hold-off clears all state immediately. The first request after reset release is accepted.

Test Plan:
- Reset, then HOLDOFF=0, WRAP_MODE=1, inc held high for 9 cycles -> ptr goes 1,2,…,7,0,1; wrap_p fires once, on the 7->0 step; slip_cnt=1; with phase[i] driven by distinct patterns, clk_early=phase[ptr], clk_edge=phase[(ptr+2)%8], clk_late=phase[(ptr+4)%8].
- HOLDOFF=2, inc pulses on cycles 0,1,2,3 -> ptr steps 0->1 at cycle 0, drop at cycles 1 and 2, ptr 1->2 at cycle 3; busy high for 2 cycles after each accepted step.
- WRAP_MODE=0, ptr=7, inc -> ptr stays 7, drop=1, busy=0, wrap_p=0; then ptr=0, dec -> ptr stays 0, drop=1; slip_cnt stays 0.
- inc=dec=1 at ptr=3 -> ptr stays 3, drop=1; then load=1 with load_val=6 while busy=1 -> ptr=6, no drop, busy restarts for HOLDOFF cycles.
- SW=4, 9 consecutive dec wraps (HOLDOFF=0, ptr cycled repeatedly through 0) -> slip_cnt reaches -8 and holds; a reset mid-sequence returns ptr, slip_cnt, busy and all pulses to 0 immediately.
